wb_arbiter2: RTL and testbench

Two-master, one-slave Wishbone arbiter that shares a single classic-cycle peripheral (for example the LED/debug slave) between two requesters, such as the CPU data bus and a debug/DMA master. Arbitration is round-robin with bus locking for the full duration of the owning master's CYC. The block sits between the masters and the slave's address decode, and it muxes address, data, write enable and strobes to the slave. It routes ACK back only to the owner.

---
 rtl/wb_arbiter2.sv | 166 ++++++++++++++++
 tb/tb_wb_arbiter2.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone classic arbiter: round-robin, bus locked for the owner's whole CYC.
// Optional slave-ACK timeout with bus error enabled by `define WB_ARBITER2_TIMEOUT_EN.
module wb_arbiter2 #(
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst,

    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    input  logic        s_ack_i,

    output logic [1:0]  gnt_o
);

    // Handshake: a slave beat happens on a rising edge where s_cyc_o & s_stb_o & s_ack_i;
    // ACK (or ERR) is routed only to the current owner and is valid for that single cycle.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;

    logic        own_cyc, own_stb, own_we;
    logic [31:0] own_adr, own_dat;
    logic        timeout_hit;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                    state_d = OWN0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = OWN1;
                    last_d  = 1'b1;
                end
            end
            OWN0: begin
                if (!m0_cyc_i) begin
                    if (m1_cyc_i) begin
                        state_d = OWN1;
                        last_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            OWN1: begin
                if (!m1_cyc_i) begin
                    if (m0_cyc_i) begin
                        state_d = OWN0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Owner mux; IDLE drives everything to zero so the slave sees a quiet bus.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = 32'h0;
        own_dat = 32'h0;
        case (state_q)
            OWN0: begin
                own_cyc = m0_cyc_i;
                own_stb = m0_stb_i;
                own_we  = m0_we_i;
                own_adr = m0_adr_i;
                own_dat = m0_dat_i;
            end
            OWN1: begin
                own_cyc = m1_cyc_i;
                own_stb = m1_stb_i;
                own_we  = m1_we_i;
                own_adr = m1_adr_i;
                own_dat = m1_dat_i;
            end
            default: ;
        endcase
    end

`ifdef WB_ARBITER2_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] to_cnt_q;

    assign timeout_hit = own_stb && (to_cnt_q == TIMEOUT_W'(TIMEOUT));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            to_cnt_q <= '0;
        end else if ((state_d != state_q) || !own_stb || s_ack_i || timeout_hit) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign timeout_hit = 1'b0;
    assign unused_cfg  = (TIMEOUT > 0) && (TIMEOUT_W > 0);
`endif

    // The timeout cycle masks the strobe and replaces any ack with err.
    assign s_cyc_o  = own_cyc;
    assign s_stb_o  = own_stb && !timeout_hit;
    assign s_we_o   = own_we;
    assign s_adr_o  = own_adr;
    assign s_dat_o  = own_dat;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    assign m0_ack_o = (state_q == OWN0) && s_ack_i && !timeout_hit;
    assign m1_ack_o = (state_q == OWN1) && s_ack_i && !timeout_hit;
    assign m0_err_o = (state_q == OWN0) && timeout_hit;
    assign m1_err_o = (state_q == OWN1) && timeout_hit;

    assign gnt_o    = {state_q == OWN1, state_q == OWN0};

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed self-checking bench for wb_arbiter2: grant order, lock, handover, async reset,
// idle ack filtering and the slave-ACK timeout (both builds of WB_ARBITER2_TIMEOUT_EN).
module tb_wb_arbiter2;

    logic        sys_clk;
    logic        sys_rst;
    logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
    logic        m0_cyc_i, m0_stb_i, m0_we_i, m0_ack_o, m0_err_o;
    logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i, m1_ack_o, m1_err_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i;
    logic [1:0]  gnt_o;

    logic [31:0] exp_q[$];
    int          n_checks;
    int          n_pass;
    int          ack0_cnt;
    int          ack1_cnt;
    int          a0_snap;

    wb_arbiter2 #(.TIMEOUT(4), .TIMEOUT_W(8)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .m0_adr_i (m0_adr_i),
        .m0_dat_i (m0_dat_i),
        .m0_dat_o (m0_dat_o),
        .m0_cyc_i (m0_cyc_i),
        .m0_stb_i (m0_stb_i),
        .m0_we_i  (m0_we_i),
        .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m1_adr_i (m1_adr_i),
        .m1_dat_i (m1_dat_i),
        .m1_dat_o (m1_dat_o),
        .m1_cyc_i (m1_cyc_i),
        .m1_stb_i (m1_stb_i),
        .m1_we_i  (m1_we_i),
        .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_dat_i  (s_dat_i),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_ack_i  (s_ack_i),
        .gnt_o    (gnt_o)
    );

    // clock / reset
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ack0_cnt <= 0;
            ack1_cnt <= 0;
        end else begin
            if (m0_ack_o) ack0_cnt <= ack0_cnt + 1;
            if (m1_ack_o) ack1_cnt <= ack1_cnt + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic check_pop(input string tag, input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            n_checks++;
            $error("FAIL %s: observed 0x%08h expected queue empty", tag, obs);
        end else begin
            check(tag, obs, exp_q.pop_front());
        end
    endtask

    task automatic drive_m0(input logic cyc, input logic stb, input logic we,
                            input logic [31:0] adr, input logic [31:0] dat);
        m0_cyc_i = cyc;
        m0_stb_i = stb;
        m0_we_i  = we;
        m0_adr_i = adr;
        m0_dat_i = dat;
    endtask

    task automatic drive_m1(input logic cyc, input logic stb, input logic we,
                            input logic [31:0] adr, input logic [31:0] dat);
        m1_cyc_i = cyc;
        m1_stb_i = stb;
        m1_we_i  = we;
        m1_adr_i = adr;
        m1_dat_i = dat;
    endtask

    task automatic pulse_reset();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        sys_rst  = 1'b1;
        s_ack_i  = 1'b0;
        s_dat_i  = 32'h0;
        drive_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();

        // reset state
        check("rst_gnt", 32'(gnt_o), 32'h0);
        check("rst_s_cyc", 32'(s_cyc_o), 32'h0);
        check("rst_s_stb", 32'(s_stb_o), 32'h0);
        check("rst_s_adr", s_adr_o, 32'h0);
        check("rst_acks", 32'({m1_ack_o, m0_ack_o, m1_err_o, m0_err_o}), 32'h0);
        sys_rst = 1'b0;
        tick();

        // single m0 write, slave acks after one wait cycle
        drive_m0(1'b1, 1'b1, 1'b1, 32'h6000_0000, 32'h0000_0001);
        exp_q.push_back(32'h6000_0000);
        exp_q.push_back(32'h0000_0001);
        #1;
        check("t1_gnt_pre", 32'(gnt_o), 32'h0);
        check("t1_s_cyc_pre", 32'(s_cyc_o), 32'h0);
        a0_snap = ack0_cnt;
        tick();
        check("t1_gnt", 32'(gnt_o), 32'h1);
        check("t1_s_cyc_stb_we", 32'({s_cyc_o, s_stb_o, s_we_o}), 32'h7);
        check_pop("t1_s_adr", s_adr_o);
        check_pop("t1_s_dat", s_dat_o);
        tick();
        check("t1_ack_wait", 32'(m0_ack_o), 32'h0);
        s_ack_i = 1'b1;
        #1;
        check("t1_m0_ack", 32'(m0_ack_o), 32'h1);
        check("t1_m1_ack", 32'(m1_ack_o), 32'h0);
        tick();
        s_ack_i = 1'b0;
        drive_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("t1_ack0_pulses", 32'(ack0_cnt - a0_snap), 32'h1);
        check("t1_ack1_pulses", 32'(ack1_cnt), 32'h0);
        tick();
        check("t1_gnt_rel", 32'(gnt_o), 32'h0);

        // tie after reset, handover, then tie goes back to m0
        pulse_reset();
        drive_m0(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        drive_m1(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        tick();
        check("t2_tie_first", 32'(gnt_o), 32'h1);
        check("t2_s_adr_m0", s_adr_o, 32'h10);
        drive_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check("t2_handover", 32'(gnt_o), 32'h2);
        check("t2_s_adr_m1", s_adr_o, 32'h20);
        drive_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check("t2_idle", 32'(gnt_o), 32'h0);
        drive_m0(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        drive_m1(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        tick();
        check("t2_tie_second", 32'(gnt_o), 32'h1);
        drive_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // m1 locks the bus for three reads while m0 waits
        drive_m1(1'b1, 1'b1, 1'b0, 32'h6000_0004, 32'h0);
        tick();
        check("t3_gnt_m1", 32'(gnt_o), 32'h2);
        drive_m0(1'b1, 1'b1, 1'b0, 32'h6000_0008, 32'h0);
        for (int i = 0; i < 3; i++) begin
            s_dat_i = 32'h0000_FFFF;
            exp_q.push_back(32'h0000_FFFF);
            s_ack_i = 1'b1;
            #1;
            check("t3_gnt_lock", 32'(gnt_o), 32'h2);
            check("t3_m1_ack", 32'(m1_ack_o), 32'h1);
            check("t3_m0_ack", 32'(m0_ack_o), 32'h0);
            check_pop("t3_m1_dat", m1_dat_o);
            tick();
            s_ack_i = 1'b0;
            s_dat_i = 32'(i);
            tick();
        end
        drive_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("t3_gnt_drop", 32'(gnt_o), 32'h2);
        tick();
        check("t3_gnt_m0", 32'(gnt_o), 32'h1);
        drive_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // asynchronous reset mid-transfer
        drive_m0(1'b1, 1'b1, 1'b1, 32'h6000_0000, 32'h5);
        tick();
        check("t4_owned", 32'({s_cyc_o, s_stb_o}), 32'h3);
        sys_rst = 1'b1;
        s_ack_i = 1'b1;
        #1;
        check("t4_async_cyc_stb", 32'({s_cyc_o, s_stb_o}), 32'h0);
        check("t4_async_gnt", 32'(gnt_o), 32'h0);
        check("t4_async_ack", 32'({m1_ack_o, m0_ack_o}), 32'h0);
        tick();
        sys_rst = 1'b0;
        s_ack_i = 1'b0;
        #1;
        check("t4_post_idle", 32'(gnt_o), 32'h0);
        tick();
        check("t4_regrant", 32'(gnt_o), 32'h1);
        drive_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // slave ack while idle is dropped
        s_ack_i = 1'b1;
        #1;
        check("t5_idle_acks", 32'({m1_ack_o, m0_ack_o}), 32'h0);
        tick();
        check("t5_idle_gnt", 32'(gnt_o), 32'h0);
        s_ack_i = 1'b0;
        tick();

        // slave never acks m0
        drive_m0(1'b1, 1'b1, 1'b0, 32'h6000_0010, 32'h0);
        tick();
        check("t6_gnt", 32'(gnt_o), 32'h1);
        check("t6_err_at_grant", 32'(m0_err_o), 32'h0);
`ifdef WB_ARBITER2_TIMEOUT_EN
        for (int i = 1; i < 4; i++) begin
            tick();
            check("t6_err_early", 32'(m0_err_o), 32'h0);
        end
        tick();
        check("t6_err_pulse", 32'(m0_err_o), 32'h1);
        check("t6_ack_with_err", 32'(m0_ack_o), 32'h0);
        check("t6_stb_masked", 32'(s_stb_o), 32'h0);
        check("t6_m1_err", 32'(m1_err_o), 32'h0);
        drive_m0(1'b1, 1'b0, 1'b0, 32'h6000_0010, 32'h0);
        tick();
        check("t6_err_single", 32'(m0_err_o), 32'h0);
`else
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t6_err_none", 32'(m0_err_o), 32'h0);
            check("t6_still_owned", 32'(gnt_o), 32'h1);
        end
`endif
        drive_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check("t6_release", 32'(gnt_o), 32'h0);
        check("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
